// File: rtl/tokens_pkg.sv
// Shared handshake type and pointer/count width helpers for the tokens FIFO family.
package tokens_pkg;

    typedef struct packed {
        logic vld;
        logic rdy;
    } hs_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic hs_fire(input hs_t hs);
        return hs.vld & hs.rdy;
    endfunction

endpackage

// File: rtl/tokens_sfifo_mem.sv
// DW x DP storage array for tokens_sfifo: one write port, one asynchronous read port, no reset.
module tokens_sfifo_mem #(
    parameter int unsigned DW = 32,
    parameter int unsigned DP = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DP];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tokens_sfifo.sv
// Synchronous valid/ready FIFO with show-ahead or registered output stage.
// Optional occupancy port enabled by defining TOKENS_SFIFO_CNT_EN.
module tokens_sfifo
    import tokens_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned DP   = 8,
    parameter int unsigned FWFT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          src_vld,
    output logic          src_rdy,
    input  logic [DW-1:0] src_dat,
    output logic          dst_vld,
    input  logic          dst_rdy,
    output logic [DW-1:0] dst_dat
`ifdef TOKENS_SFIFO_CNT_EN
    ,
    output logic [cnt_w(DP)-1:0] cnt
`endif
);

    localparam int unsigned AW = ptr_w(DP);
    localparam int unsigned CW = cnt_w(DP);
    localparam logic [AW-1:0] PTR_LAST = AW'(DP - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DP);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] mem_cnt;
    logic [CW-1:0] tot_cnt;
    logic [CW-1:0] tot_cnt_nxt;
    logic [DW-1:0] rd_dat;
    logic          push;
    logic          pop;
    logic          out_free;
    logic          ld_out;
    logic          bypass;
    logic          mem_we;

    assign push     = hs_fire(hs_t'{vld: src_vld, rdy: src_rdy});
    assign pop      = hs_fire(hs_t'{vld: dst_vld, rdy: dst_rdy});
    assign out_free = !dst_vld || pop;

    // Storage always feeds the output stage first; in show-ahead mode an empty
    // storage lets the incoming word go straight to the output register.
    assign ld_out      = out_free && (mem_cnt != '0);
    assign bypass      = (FWFT != 0) && push && out_free && (mem_cnt == '0);
    assign mem_we      = push && !bypass;
    assign tot_cnt_nxt = tot_cnt + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            tot_cnt <= '0;
            src_rdy <= 1'b0;
            dst_vld <= 1'b0;
            dst_dat <= '0;
        end else begin
            if (mem_we) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (ld_out) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            end
            mem_cnt <= mem_cnt + CW'(mem_we) - CW'(ld_out);
            tot_cnt <= tot_cnt_nxt;
            src_rdy <= (tot_cnt_nxt != CNT_FULL);
            if (ld_out) begin
                dst_vld <= 1'b1;
                dst_dat <= rd_dat;
            end else if (bypass) begin
                dst_vld <= 1'b1;
                dst_dat <= src_dat;
            end else if (pop) begin
                dst_vld <= 1'b0;
            end
        end
    end

`ifdef TOKENS_SFIFO_CNT_EN
    assign cnt = tot_cnt;
`endif

    tokens_sfifo_mem #(
        .DW(DW),
        .DP(DP),
        .AW(AW)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wr_ptr),
        .wdata(src_dat),
        .raddr(rd_ptr),
        .rdata(rd_dat)
    );

endmodule

// File: tb/tb_tokens_sfifo.sv
// Scoreboard bench for tokens_sfifo: four instances (DP 8/5 x FWFT 1/0), directed then random traffic.
module tb_tokens_sfifo;

    localparam int unsigned DW = 32;
    localparam int NI     = 4;
    localparam int NWORDS = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          src_vld [NI];
    logic          src_rdy [NI];
    logic [DW-1:0] src_dat [NI];
    logic          dst_vld [NI];
    logic          dst_rdy [NI];
    logic [DW-1:0] dst_dat [NI];

    logic          dir_vld [NI];
    logic [DW-1:0] dir_dat [NI];
    logic          dir_rdy [NI];
    bit            rnd_en = 1'b0;
    bit            done_g [NI];
    int            qlen [NI];

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    for (genvar g = 0; g < NI; g++) begin : u
        localparam int DPG = (g < 2) ? 8 : 5;
        localparam int FWG = (g % 2 == 0) ? 1 : 0;

        logic [DW-1:0] q [$];
`ifdef TOKENS_SFIFO_CNT_EN
        logic [$clog2(DPG+1)-1:0] cnt_s;
`endif

        tokens_sfifo #(
            .DW  (DW),
            .DP  (DPG),
            .FWFT(FWG)
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .src_vld(src_vld[g]),
            .src_rdy(src_rdy[g]),
            .src_dat(src_dat[g]),
            .dst_vld(dst_vld[g]),
            .dst_rdy(dst_rdy[g]),
            .dst_dat(dst_dat[g])
`ifdef TOKENS_SFIFO_CNT_EN
            ,
            .cnt    (cnt_s)
`endif
        );

        // Stimulus: drive at the falling edge, log accepted words into the expected queue.
        initial begin : drv
            int pushed;
            int ncyc;
            pushed = 0;
            ncyc   = 0;
            src_vld[g] = 1'b0;
            src_dat[g] = '0;
            dst_rdy[g] = 1'b0;
            done_g[g]  = 1'b0;
            forever begin
                @(negedge clk);
                if (rnd_en) begin
                    src_vld[g] = (pushed < NWORDS) && ($urandom_range(0, 99) < 70);
                    src_dat[g] = $urandom;
                    dst_rdy[g] = ($urandom_range(0, 99) < (((ncyc / 64) % 2 == 0) ? 30 : 85));
                    ncyc++;
                end else begin
                    src_vld[g] = dir_vld[g];
                    src_dat[g] = dir_dat[g];
                    dst_rdy[g] = dir_rdy[g];
                end
                #1;
                if (rst) begin
                    q.delete();
                end else if (src_vld[g] && src_rdy[g]) begin
                    q.push_back(src_dat[g]);
                    if (rnd_en) pushed++;
                end
                done_g[g] = (pushed >= NWORDS);
            end
        end

        // Monitor: occupancy model, hold-while-stalled, and in-order data on every pop.
        initial begin : mon
            int            mcount;
            bit            pv;
            logic [DW-1:0] pd;
            bit            was_rst;
            logic [DW-1:0] exp;
            mcount  = 0;
            pv      = 1'b0;
            pd      = '0;
            was_rst = 1'b1;
            forever begin
                @(negedge clk);
                #2;
                if (rst || was_rst) begin
                    mcount  = 0;
                    pv      = 1'b0;
                    was_rst = rst;
                end else begin
                    check($sformatf("u%0d.src_rdy", g), DW'(src_rdy[g]), DW'(mcount != DPG));
                    check($sformatf("u%0d.dst_vld", g), DW'(dst_vld[g]),
                          DW'((mcount != 0) && (FWG == 1 || dst_vld[g])));
`ifdef TOKENS_SFIFO_CNT_EN
                    check($sformatf("u%0d.cnt", g), DW'(cnt_s), DW'(mcount));
`endif
                    if (pv) begin
                        check($sformatf("u%0d.hold_vld", g), DW'(dst_vld[g]), DW'(1));
                        check($sformatf("u%0d.hold_dat", g), dst_dat[g], pd);
                    end
                    if (dst_vld[g] && dst_rdy[g]) begin
                        if (q.size() == 0) begin
                            n_chk++;
                            $display("FAIL u%0d.pop_empty: popped 0x%h, expected no word (t=%0t)",
                                     g, dst_dat[g], $time);
                        end else begin
                            exp = q.pop_front();
                            check($sformatf("u%0d.data", g), dst_dat[g], exp);
                        end
                    end
                    mcount = mcount + int'(src_vld[g] && src_rdy[g]) - int'(dst_vld[g] && dst_rdy[g]);
                    pv = dst_vld[g] && !dst_rdy[g];
                    pd = dst_dat[g];
                end
                qlen[g] = q.size();
            end
        end
    end

    function automatic bit all_done();
        bit d;
        d = 1'b1;
        for (int i = 0; i < NI; i++) d = d && done_g[i];
        return d;
    endfunction

    initial begin : main
        int c;
        for (int i = 0; i < NI; i++) begin
            dir_vld[i] = 1'b0;
            dir_dat[i] = '0;
            dir_rdy[i] = 1'b0;
        end

        // Reset held three cycles, then released.
        repeat (3) cyc();
        for (int i = 0; i < NI; i++) begin
            check("reset_src_rdy", DW'(src_rdy[i]), DW'(0));
            check("reset_dst_vld", DW'(dst_vld[i]), DW'(0));
            check("reset_dst_dat", dst_dat[i], DW'(0));
        end
        rst = 1'b0;
        cyc();
        for (int i = 0; i < NI; i++) begin
            check("post_reset_src_rdy", DW'(src_rdy[i]), DW'(1));
            check("post_reset_dst_vld", DW'(dst_vld[i]), DW'(0));
        end

        // Show-ahead single word.
        dir_vld[0] = 1'b1;
        dir_dat[0] = 32'hDEADBEEF;
        cyc();
        dir_vld[0] = 1'b0;
        check("fwft_single_vld", DW'(dst_vld[0]), DW'(1));
        check("fwft_single_dat", dst_dat[0], 32'hDEADBEEF);
        dir_rdy[0] = 1'b1;
        cyc();
        dir_rdy[0] = 1'b0;
        check("fwft_single_popped", DW'(dst_vld[0]), DW'(0));

        // Fill to capacity with the consumer stalled.
        for (int i = 1; i <= 8; i++) begin
            dir_vld[0] = 1'b1;
            dir_dat[0] = DW'(i);
            cyc();
            check($sformatf("fill_src_rdy_%0d", i), DW'(src_rdy[0]), DW'(i < 8));
        end
        dir_dat[0] = DW'(9);
        cyc();
        check("full_refuse_src_rdy", DW'(src_rdy[0]), DW'(0));
        check("full_head_dat", dst_dat[0], DW'(1));

        // Full with simultaneous push attempt and pop.
        dir_rdy[0] = 1'b1;
        cyc();
        dir_vld[0] = 1'b0;
        dir_rdy[0] = 1'b0;
        check("full_pop_src_rdy", DW'(src_rdy[0]), DW'(1));
        check("full_pop_next_dat", dst_dat[0], DW'(2));
        dir_rdy[0] = 1'b1;
        repeat (7) cyc();
        dir_rdy[0] = 1'b0;
        check("drain_empty_vld", DW'(dst_vld[0]), DW'(0));
        check("drain_empty_q", DW'(qlen[0]), DW'(0));

        // Registered-output latency.
        dir_vld[1] = 1'b1;
        dir_dat[1] = DW'(1);
        cyc();
        dir_vld[1] = 1'b0;
        check("reg_lat_edge_n", DW'(dst_vld[1]), DW'(0));
        cyc();
        check("reg_lat_edge_n1_vld", DW'(dst_vld[1]), DW'(1));
        check("reg_lat_edge_n1_dat", dst_dat[1], DW'(1));
        dir_rdy[1] = 1'b1;
        cyc();
        dir_rdy[1] = 1'b0;
        check("reg_lat_popped", DW'(dst_vld[1]), DW'(0));

        // Random streaming on all four configurations.
        rnd_en = 1'b1;
        c = 0;
        while (!all_done() && c < 20000) begin
            cyc();
            c++;
        end
        check("stream_done", DW'(all_done()), DW'(1));
        for (int i = 0; i < NI; i++) begin
            dir_vld[i] = 1'b0;
            dir_rdy[i] = 1'b1;
        end
        rnd_en = 1'b0;
        repeat (20) cyc();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("final_q_u%0d", i), DW'(qlen[i]), DW'(0));
            check($sformatf("final_vld_u%0d", i), DW'(dst_vld[i]), DW'(0));
            check($sformatf("final_rdy_u%0d", i), DW'(src_rdy[i]), DW'(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tokens_sfifo.md
TOKENS_SFIFO -- requirements
Module: tokens_sfifo

Interface
REQ-001 Parameter DW, default 32, data width in bits (>=1).
REQ-002 Parameter DP, default 8, depth in entries (>=2, any integer).
REQ-003 Parameter FWFT, default 1, first-word-fall-through select: 1 = show-ahead, 0 = registered output stage.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 src_vld  input  1  producer offers src_dat.
REQ-008 src_rdy  output  1  FIFO can accept a word.
REQ-009 src_dat  input  DW  write data.
REQ-010 dst_vld  output  1  dst_dat holds a valid word.
REQ-011 dst_rdy  input  1  consumer accepts dst_dat.
REQ-012 dst_dat  output  DW  read data.

Function
REQ-013 Push occurs on a rising edge with src_vld&&src_rdy; pop occurs with dst_vld&&dst_rdy.
REQ-014 Words leave in strict arrival order; none lost, duplicated or reordered.
REQ-015 Total capacity is exactly DP words, including any output-stage word.
REQ-016 src_rdy = not full, registered or derived from state only, never combinationally dependent on dst_rdy or src_vld.
REQ-017 When full, a simultaneous push attempt is refused (src_rdy=0) even if a pop occurs that cycle.
REQ-018 When non-empty and not full, simultaneous push and pop leave the occupancy unchanged.
REQ-019 FWFT=1: a word pushed into an empty FIFO at edge N drives dst_vld=1 and dst_dat=word after edge N (one-cycle latency), with no pop needed to expose it.
REQ-020 FWFT=0: dst_dat/dst_vld come from an output register loaded from storage; latency from push into an empty FIFO to dst_vld is 2 edges.
REQ-021 dst_dat and dst_vld hold stable while dst_vld=1 and dst_rdy=0.
REQ-022 Read/write pointers wrap from DP-1 to 0; full/empty are unambiguous for non-power-of-two DP (occupancy counter or extra wrap bit).
REQ-023 dst_dat is don't-care when dst_vld=0.

Reset
REQ-024 While rst=1: src_rdy=0, dst_vld=0, dst_dat=0, pointers and occupancy cleared; pushes and pops are ignored.
REQ-025 First edge after rst falls: src_rdy=1, dst_vld=0.
REQ-026 Reset mid-operation discards all stored words; storage array need not be cleared.

Configuration
REQ-027 Macro TOKENS_SFIFO_CNT_EN defined: adds output port cnt, width $clog2(DP+1), equal to words held (including any output-stage word), 0 in reset.
REQ-028 Macro undefined: no cnt port; all other behaviour identical.

Structure
REQ-029 Package tokens_pkg holds shared handshake typedefs and the pointer/count width helper function; tokens_sfifo imports it.
REQ-030 Storage is a sub-module tokens_sfifo_mem (DW x DP array, one write port, one read port, no reset).

Verification
REQ-031 Reset: hold rst 3 cycles -> src_rdy=0, dst_vld=0; after release -> src_rdy=1, dst_vld=0.
REQ-032 FWFT=1 single word: push 32'hDEADBEEF into empty FIFO -> dst_vld=1 with dst_dat=32'hDEADBEEF the next cycle; pop -> dst_vld=0.
REQ-033 Fill: push 8 words 1..8 with dst_rdy=0 -> src_rdy=0 after the 8th; 9th push refused; drain -> 1..8 in order.
REQ-034 Full + simultaneous: full FIFO, src_vld=1, dst_rdy=1 for one cycle -> one word popped, none pushed; next cycle src_rdy=1.
REQ-035 Streaming: 1000 random words, random src_vld/dst_rdy, FWFT in {0,1}, DP in {8,5} -> scoreboard matches exactly, wrap exercised.
REQ-036 FWFT=0 latency: push 32'h1 into empty FIFO at edge N -> dst_vld=1 after edge N+1.
